// File: rtl/seven_seg_pkg.sv
// Shared 7-segment encodings and monitor state type; the display driver's segment
// table is built from the same constants so both ends agree on bit order.
package seven_seg_pkg;

    localparam int unsigned SegWidth = 7;

    // Bit position of each segment on the pins: a = top, g = middle.
    localparam int unsigned SegABit = 0;
    localparam int unsigned SegBBit = 1;
    localparam int unsigned SegCBit = 2;
    localparam int unsigned SegDBit = 3;
    localparam int unsigned SegEBit = 4;
    localparam int unsigned SegFBit = 5;
    localparam int unsigned SegGBit = 6;

    localparam logic [SegWidth-1:0] SegA = SegWidth'(1 << SegABit);
    localparam logic [SegWidth-1:0] SegB = SegWidth'(1 << SegBBit);
    localparam logic [SegWidth-1:0] SegC = SegWidth'(1 << SegCBit);
    localparam logic [SegWidth-1:0] SegD = SegWidth'(1 << SegDBit);
    localparam logic [SegWidth-1:0] SegE = SegWidth'(1 << SegEBit);
    localparam logic [SegWidth-1:0] SegF = SegWidth'(1 << SegFBit);
    localparam logic [SegWidth-1:0] SegG = SegWidth'(1 << SegGBit);

    localparam logic [SegWidth-1:0] SEG_0     = SegA | SegB | SegC | SegD | SegE | SegF;
    localparam logic [SegWidth-1:0] SEG_1     = SegB | SegC;
    localparam logic [SegWidth-1:0] SEG_2     = SegA | SegB | SegD | SegE | SegG;
    localparam logic [SegWidth-1:0] SEG_3     = SegA | SegB | SegC | SegD | SegG;
    localparam logic [SegWidth-1:0] SEG_4     = SegB | SegC | SegF | SegG;
    localparam logic [SegWidth-1:0] SEG_5     = SegA | SegC | SegD | SegF | SegG;
    localparam logic [SegWidth-1:0] SEG_6     = SegC | SegD | SegE | SegF | SegG;
    localparam logic [SegWidth-1:0] SEG_7     = SegA | SegB | SegC;
    localparam logic [SegWidth-1:0] SEG_8     = SegA | SegB | SegC | SegD | SegE | SegF | SegG;
    localparam logic [SegWidth-1:0] SEG_9     = SegA | SegB | SegC | SegF | SegG;
    localparam logic [SegWidth-1:0] SEG_BLANK = '0;

    typedef enum logic {
        StUnlocked,
        StLocked
    } mon_state_e;

    function automatic logic [3:0] next_digit(input logic [3:0] digit);
        return (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
    endfunction

    function automatic logic [SegWidth-1:0] seg_encode(input logic [3:0] digit);
        logic [SegWidth-1:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to BCD decoder; anything that is neither a digit nor
// blank is reported through is_digit_o = is_blank_o = 0.
module seg7_decode
    import seven_seg_pkg::*;
(
    input  logic [SegWidth-1:0] pattern_i,
    output logic [3:0]          digit_o,
    output logic                is_digit_o,
    output logic                is_blank_o
);

    always_comb begin
        digit_o    = 4'd0;
        is_digit_o = 1'b1;
        is_blank_o = 1'b0;
        case (pattern_i)
            SEG_0:     digit_o = 4'd0;
            SEG_1:     digit_o = 4'd1;
            SEG_2:     digit_o = 4'd2;
            SEG_3:     digit_o = 4'd3;
            SEG_4:     digit_o = 4'd4;
            SEG_5:     digit_o = 4'd5;
            SEG_6:     digit_o = 4'd6;
            SEG_7:     digit_o = 4'd7;
            SEG_8:     digit_o = 4'd8;
            SEG_9:     digit_o = 4'd9;
            SEG_BLANK: begin
                is_digit_o = 1'b0;
                is_blank_o = 1'b1;
            end
            default:   is_digit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_monitor.sv
// Watches a 7-segment digit stream: synchronises and debounces the pins, decodes each
// stable pattern and checks that digits count 0..9 with wrap, flagging errors and stalls.
module seven_segment_monitor
    import seven_seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SegWidth-1:0] seg_in,
    output logic [3:0]          digit_out,
    output logic                digit_valid,
    output logic                blank,
    output logic                locked,
    output logic                seq_error,
    output logic                invalid_pattern,
    output logic                stall,
    output logic [7:0]          error_count
);

    localparam int unsigned        StabW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [StabW-1:0]   StabMax    = StabW'(STABLE_CYCLES);
    localparam logic [15:0]        TimeoutMax = 16'(TIMEOUT_CYCLES);

    logic [SegWidth-1:0] sync1_q, sync2_q, acc_q;
    logic [StabW-1:0]    stab_q, stab_d;
    logic [15:0]         tmo_q, tmo_d;
    logic                accept;
    mon_state_e          state_q;
    logic [3:0]          expected_q, digit_q;
    logic                dv_q, se_q, ip_q;
    logic [7:0]          err_q;

    logic [3:0]          dec_digit;
    logic                dec_is_digit, dec_is_blank;

    seg7_decode u_decode (
        .pattern_i  (sync2_q),
        .digit_o    (dec_digit),
        .is_digit_o (dec_is_digit),
        .is_blank_o (dec_is_blank)
    );

    // stab_q counts cycles the synced value has held; a differing sync1 means it changes now.
    always_comb begin
        accept = (stab_q == StabMax) && (sync2_q != acc_q);
        stab_d = stab_q;
        if (sync1_q != sync2_q) begin
            stab_d = '0;
        end else if (stab_q != StabMax) begin
            stab_d = stab_q + StabW'(1);
        end
        tmo_d = tmo_q;
        if (accept) begin
            tmo_d = '0;
        end else if (tmo_q != TimeoutMax) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= SEG_BLANK;
            sync2_q    <= SEG_BLANK;
            acc_q      <= SEG_BLANK;
            stab_q     <= '0;
            tmo_q      <= '0;
            state_q    <= StUnlocked;
            expected_q <= 4'd0;
            digit_q    <= 4'd0;
            dv_q       <= 1'b0;
            se_q       <= 1'b0;
            ip_q       <= 1'b0;
            err_q      <= 8'd0;
        end else begin
            sync1_q <= seg_in;
            sync2_q <= sync1_q;
            stab_q  <= stab_d;
            tmo_q   <= tmo_d;
            dv_q    <= 1'b0;
            se_q    <= 1'b0;
            ip_q    <= 1'b0;
            if (accept) begin
                acc_q <= sync2_q;
                if (dec_is_digit) begin
                    digit_q    <= dec_digit;
                    dv_q       <= 1'b1;
                    expected_q <= next_digit(dec_digit);
                    state_q    <= StLocked;
                    if (state_q == StLocked && dec_digit != expected_q) begin
                        se_q <= 1'b1;
                        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                    end
                end else if (dec_is_blank) begin
                    state_q <= StUnlocked;
                end else begin
                    ip_q    <= 1'b1;
                    state_q <= StUnlocked;
                    if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                end
            end
        end
    end

    assign digit_out       = digit_q;
    assign digit_valid     = dv_q;
    assign seq_error       = se_q;
    assign invalid_pattern = ip_q;
    assign error_count     = err_q;
    assign blank           = (acc_q == SEG_BLANK);
    assign locked          = (state_q == StLocked);
    assign stall           = (tmo_q == TimeoutMax);

endmodule
